// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial line, CPU pop/clear strobes and FIFO/status view.
// master: line + CPU side (uart_rx, rd_en, clr_status out; FIFO view in).
// slave : receiver side (line/strobes in; rd_data, flags, count, status, irq out).
interface uart_rx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              uart_rx;
    logic              rd_en;
    logic              clr_status;
    logic [DATA_W-1:0] rd_data;
    logic              rx_empty;
    logic              rx_full;
    logic [CW-1:0]     rx_count;
    logic [2:0]        status;
    logic              rx_irq;

    modport master (
        output uart_rx, rd_en, clr_status,
        input  rd_data, rx_empty, rx_full, rx_count, status, rx_irq
    );

    modport slave (
        input  uart_rx, rd_en, clr_status,
        output rd_data, rx_empty, rx_full, rx_count, status, rx_irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a FWFT receive FIFO,
// with sticky status {overrun, parity_err, frame_err} and a level IRQ.
// Ports: clk_clk, reset_reset (sync, active high), bus (uart_rx_fifo_if.slave).
// Optional parity bit: define UART_RX_PARITY_EN (sense from PARITY_ODD).
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    uart_rx_fifo_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [LVL_W-1:0] DEPTH    = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_e;

    // Input synchronizer; third flop only for falling-edge detection.
    logic sync1_q, sync2_q, sync3_q;
    logic rx_s, fall;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= bus.uart_rx;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rx_s = sync2_q;
    assign fall = sync3_q & ~sync2_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              bad_q, bad_d;
    logic              bit_end;
    logic              push_req, frame_set;

    assign bit_end = (cnt_q == BIT_END);

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_set;
    // Data plus received parity bit must XOR to the configured sense.
    assign par_bad = (^{shift_q, rx_s}) != (PARITY_ODD != 0);
`else
    logic unused_par;
    // Parity sense has no meaning without the parity bit.
    assign unused_par = (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        bad_d   = bad_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = START;
                    bit_d   = '0;
                    bad_d   = 1'b0;
                end
            end
            START: begin
                // Half-bit wait lands every later sample mid-bit.
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bad_d   = par_bad;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_req  = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        unique case (state_q)
`ifdef UART_RX_PARITY_EN
            PARITY: par_set = bit_end && par_bad;
`endif
            STOP: begin
                push_req  = bit_end && rx_s && !bad_q;
                frame_set = bit_end && !rx_s;
            end
            default: ;
        endcase
    end

    // Receive FIFO; count is the level, pointers wrap freely.
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              empty_q, full_q;
    logic              pop, do_push, ovr_set;

    assign pop     = bus.rd_en & ~empty_q;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_req & (~full_q | pop);
    assign ovr_set = push_req & full_q & ~pop;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DEPTH);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset && do_push) mem_q[wr_q] <= shift_q;
    end

    // Sticky status: an event in the clear cycle still sets its bit.
    logic [2:0] status_q, status_d;

    always_comb begin
        status_d[0] = frame_set | (status_q[0] & ~bus.clr_status);
`ifdef UART_RX_PARITY_EN
        status_d[1] = par_set | (status_q[1] & ~bus.clr_status);
`else
        status_d[1] = 1'b0;
`endif
        status_d[2] = ovr_set | (status_q[2] & ~bus.clr_status);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) status_q <= '0;
        else             status_q <= status_d;
    end

    assign bus.rd_data  = empty_q ? '0 : mem_q[rd_q];
    assign bus.rx_empty = empty_q;
    assign bus.rx_full  = full_q;
    assign bus.rx_count = count_q;
    assign bus.status   = status_q;
    assign bus.rx_irq   = ~empty_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vectors for uart_rx_fifo, CLKS_PER_BIT=8,
// DATA_W=8, FIFO_DEPTH=4; inputs change and outputs are read on negedges.
module tb_uart_rx_fifo;
    localparam int CPB   = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk_clk     = 1'b0;
    logic reset_reset = 1'b1;

    uart_rx_fifo_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .PARITY_ODD  (0)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .bus        (bus)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [7:0] data;
        bit         stop_hi;
        int         pops;
        int         cnt;
        logic [7:0] head;
        bit         full;
        logic [2:0] st;
    } vec_t;

    vec_t       tbl [12];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] q [$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One bit time; optional strobes land on the receiver's sample cycle.
    task automatic send_bit(input logic v, input bit pr, input bit pc);
        bus.uart_rx = v;
        tick(CPB - 2);
        bus.rd_en      = pr;
        bus.clr_status = pc;
        tick(1);
        bus.rd_en      = 1'b0;
        bus.clr_status = 1'b0;
        tick(1);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_hi,
                              input bit par_ok, input bit pr,
                              input bit pc, input bit pc_par);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i], 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
        send_bit(par_ok ? ^d : ~^d, 1'b0, pc_par);
`endif
        send_bit(stop_hi, pr, pc);
    endtask

    task automatic mpush(input logic [7:0] d);
        if (q.size() < DEPTH) q.push_back(d);
    endtask

    task automatic pop_chk(input string nm);
        logic [7:0] e;
        e = 8'h00;
        if (q.size() > 0) e = q.pop_front();
        chk(nm, bus.rd_data, e);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic clear_status();
        bus.clr_status = 1'b1;
        tick(1);
        bus.clr_status = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'h01, 1'b1, 0, 1, 8'h01, 1'b0, 3'b000};
        tbl[1]  = '{8'h02, 1'b1, 0, 2, 8'h01, 1'b0, 3'b000};
        tbl[2]  = '{8'h03, 1'b1, 0, 3, 8'h01, 1'b0, 3'b000};
        tbl[3]  = '{8'h04, 1'b1, 0, 4, 8'h01, 1'b1, 3'b000};
        tbl[4]  = '{8'h05, 1'b1, 3, 4, 8'h01, 1'b1, 3'b100};
        tbl[5]  = '{8'h10, 1'b1, 0, 2, 8'h04, 1'b0, 3'b100};
        tbl[6]  = '{8'h11, 1'b1, 2, 3, 8'h04, 1'b0, 3'b100};
        tbl[7]  = '{8'h12, 1'b1, 1, 2, 8'h11, 1'b0, 3'b100};
        tbl[8]  = '{8'h13, 1'b1, 1, 2, 8'h12, 1'b0, 3'b100};
        tbl[9]  = '{8'h14, 1'b1, 1, 2, 8'h13, 1'b0, 3'b100};
        tbl[10] = '{8'h15, 1'b1, 2, 2, 8'h14, 1'b0, 3'b100};
        tbl[11] = '{8'h3C, 1'b0, 0, 0, 8'h00, 1'b0, 3'b101};

        bus.uart_rx    = 1'b1;
        bus.rd_en      = 1'b0;
        bus.clr_status = 1'b0;
        reset_reset    = 1'b1;
        tick(3);
        chk("rst empty", bus.rx_empty, 1);
        chk("rst full", bus.rx_full, 0);
        chk("rst count", bus.rx_count, 0);
        chk("rst rd_data", bus.rd_data, 0);
        chk("rst status", bus.status, 0);
        chk("rst irq", bus.rx_irq, 0);
        reset_reset = 1'b0;
        tick(4);

        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("a5 empty", bus.rx_empty, 0);
        chk("a5 rd_data", bus.rd_data, 8'hA5);
        chk("a5 count", bus.rx_count, 1);
        chk("a5 irq", bus.rx_irq, 1);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        chk("a5 pop empty", bus.rx_empty, 1);
        chk("a5 pop rd_data", bus.rd_data, 0);
        chk("a5 pop irq", bus.rx_irq, 0);

        bus.uart_rx = 1'b0;
        tick(2);
        bus.uart_rx = 1'b1;
        tick(20);
        chk("glitch empty", bus.rx_empty, 1);
        chk("glitch count", bus.rx_count, 0);
        chk("glitch status", bus.status, 0);

        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(32);
        bus.uart_rx = 1'b1;
        tick(8);
        send_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        mpush(8'h11);
        chk("break status", bus.status, 3'b001);
        chk("break count", bus.rx_count, 1);
        pop_chk("break head");
        chk("break drained", bus.rx_empty, 1);
        clear_status();
        chk("clr status", bus.status, 0);

        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.uart_rx = 1'b1;
        tick(4);
        chk("frame set wins", bus.status, 3'b001);
        clear_status();

        for (int i = 0; i < 12; i++) begin
            send_frame(tbl[i].data, tbl[i].stop_hi, 1'b1, 1'b0, 1'b0, 1'b0);
            bus.uart_rx = 1'b1;
            tick(4);
            if (tbl[i].stop_hi) mpush(tbl[i].data);
            chk($sformatf("v%0d count", i), bus.rx_count, tbl[i].cnt);
            chk($sformatf("v%0d head", i), bus.rd_data, tbl[i].head);
            chk($sformatf("v%0d full", i), bus.rx_full, tbl[i].full);
            chk($sformatf("v%0d status", i), bus.status, tbl[i].st);
            for (int p = 0; p < tbl[i].pops; p++)
                pop_chk($sformatf("v%0d pop%0d", i, p));
        end
        clear_status();
        chk("tbl clr status", bus.status, 0);

        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h20 + 8'(i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            mpush(8'h20 + 8'(i));
        end
        chk("co full", bus.rx_full, 1);
        chk("co head", bus.rd_data, 8'h20);
        send_frame(8'h24, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        void'(q.pop_front());
        q.push_back(8'h24);
        tick(2);
        chk("co count", bus.rx_count, 4);
        chk("co full2", bus.rx_full, 1);
        chk("co no ovr", bus.status, 0);
        for (int i = 0; i < DEPTH; i++)
            pop_chk($sformatf("co drain%0d", i));
        chk("co empty", bus.rx_empty, 1);

        send_frame(8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        mpush(8'h77);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.uart_rx = 1'b1;
        tick(4);
        chk("pre-rst count", bus.rx_count, 1);
        chk("pre-rst status", bus.status, 3'b001);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b0);
        bus.uart_rx = 1'b1;
        tick(3);
        reset_reset = 1'b1;
        tick(1);
        reset_reset = 1'b0;
        q.delete();
        chk("mid rst empty", bus.rx_empty, 1);
        chk("mid rst full", bus.rx_full, 0);
        chk("mid rst count", bus.rx_count, 0);
        chk("mid rst rd_data", bus.rd_data, 0);
        chk("mid rst status", bus.status, 0);
        chk("mid rst irq", bus.rx_irq, 0);
        tick(30);
        chk("post rst idle", bus.rx_count, 0);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        mpush(8'h5A);
        chk("5a count", bus.rx_count, 1);
        pop_chk("5a head");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        mpush(8'h07);
        chk("par ok count", bus.rx_count, 1);
        chk("par ok status", bus.status, 0);
        pop_chk("par ok head");
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("par bad count", bus.rx_count, 0);
        chk("par bad status", bus.status, 3'b010);
        clear_status();
        chk("par clr", bus.status, 0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("par set wins", bus.status, 3'b010);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
